wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback stage plus architectural register file of the pipeline CPU.
- Consumes the ALU result and load data registered at the MEM/WB boundary.
- Selects the writeback value, applies load byte/halfword extraction and sign/zero extension, and writes the 32x32 register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass, and exports the writeback value for EX forwarding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREG, 32, number of architectural registers; register index width is log2(NREG) = 5.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- wb_valid  input  1  instruction in WB is valid (not a bubble).
- wb_reg_w_en  input  1  instruction writes rd.
- wb_rd  input  5  destination register index.
- wb_sel  input  2  writeback source: 0=ALU, 1=load, 2=pc+4, 3=ALU.
- wb_funct3  input  3  load type for extraction.
- wb_alu_out  input  32  ALU result; bits [1:0] give the load byte offset.
- wb_ld_data  input  32  raw aligned memory word.
- wb_pc_plus4  input  32  link address.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  32  read port 1 data, combinational.
- rs2_data  output  32  read port 2 data, combinational.
- wb_data  output  32  selected and extended writeback value, combinational; used for forwarding.
- wb_we_out  output  1  effective write enable: wb_valid & wb_reg_w_en & (wb_rd != 0).

Behaviour:
- Reset:
  - All NREG registers clear to 0 asynchronously on rst rising.
  - Register file holds 0 while rst is high; writes are ignored while rst is high.
  - Read outputs therefore return 0 during reset.
- Load extraction from off = wb_alu_out[1:0]:
  - funct3 000 LB: byte at off, sign-extended.
  - funct3 100 LBU: byte at off, zero-extended.
  - funct3 001 LH: halfword selected by off[1], sign-extended; off[0] ignored.
  - funct3 101 LHU: halfword selected by off[1], zero-extended; off[0] ignored.
  - funct3 010 LW, and every other code: full word.
  - Byte k occupies bits [8k+7:8k] (little-endian).
- wb_data:
  - wb_sel=0 or 3: wb_alu_out.
  - wb_sel=1: extracted load value.
  - wb_sel=2: wb_pc_plus4.
  - Zero latency from all inputs.
- Write: on rising clk, when wb_we_out=1, register[wb_rd] <= wb_data.
  - A write to x0 never occurs.
  - Bubbles (wb_valid=0) never write.
- Read, per port independently:
  - addr==0: data 0.
  - Else if wb_we_out and addr==wb_rd: data = wb_data (write-through bypass, same cycle).
  - Else: stored register value.
  - rs1 and rs2 may name the same register; both return the same value.
- Simultaneous write and read of the same register: the reader sees the new value in the same cycle and the stored value from the next cycle onward. No conflict is possible, since there is only one write port.
- Reset mid-operation: a write pending at the same edge as rst assertion is lost; the register stays 0.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt (64-bit), reset to 0.
  - Increments by 1 at each rising clk with wb_valid=1 and rst=0, regardless of wb_reg_w_en.
  - Wraps from all-ones to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - Writeback select constants WB_SEL_ALU=0, WB_SEL_LD=1, WB_SEL_PC4=2.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN and register index width.
- One natural sub-module: ld_extend (combinational: raw word, offset, funct3 -> extended value). Instantiated once; also reusable by the bench model.
- Register array, bypass, and retire counter stay in the top.

Test Plan:
- Reset check: assert rst mid-run after writing x5=0x1234_5678 -> rs1_addr=5 reads 0 immediately and after rst drops.
- Writeback sources: wb_sel=0, alu_out=0xDEAD_BEEF, rd=3 -> x3=0xDEAD_BEEF next cycle. wb_sel=2, pc_plus4=0x0000_0104, rd=1 -> x1=0x104.
- Load extension with ld_data=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80; LBU off=3 -> 0x0000_0080.
  - LB off=0 -> 0x0000_0001.
  - LH off=2 -> 0xFFFF_80FF; LHU off=2 -> 0x0000_80FF.
  - LH off=1 -> 0x0000_7F01.
  - funct3=011 -> 0x80FF_7F01.
- x0 and bubbles:
  - rd=0, write 0xFFFF_FFFF -> rs1_addr=0 reads 0; wb_we_out=0.
  - wb_valid=0, rd=7, alu_out=0x55 -> x7 is unchanged.
- Bypass: x9 holds 0x11; write rd=9 with 0x22 while rs1_addr=rs2_addr=9 -> both read 0x22 in the same cycle and in the next cycle.
- With WB_RETIRE_CNT_EN: 10 cycles with wb_valid pattern 1101101101 -> retire_cnt=7; rst -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants: datapath width, register index width,
// writeback source selects and load funct3 encodings.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_LD  = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/ld_extend.sv
// Load data extraction: picks the byte/halfword addressed by the low address
// bits from an aligned word and sign- or zero-extends it to XLEN.
module ld_extend
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = raw[7:0];
    case (off)
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase
    // Halfword accesses ignore off[0]; misaligned halves are the LSU's problem.
    half_v = off[1] ? raw[31:16] : raw[15:0];

    case (funct3)
      F3_LB:   ext = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  ext = {24'd0, byte_v};
      F3_LH:   ext = {{16{half_v[15]}}, half_v};
      F3_LHU:  ext = {16'd0, half_v};
      default: ext = raw;
    endcase
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file with write-through
// read bypass. Optional 64-bit retired-instruction counter: WB_RETIRE_CNT_EN.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_reg_w_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        wb_funct3,
  input  logic [XLEN-1:0]   wb_alu_out,
  input  logic [XLEN-1:0]   wb_ld_data,
  input  logic [XLEN-1:0]   wb_pc_plus4,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_we_out
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] ld_val;
  logic            bypass_en;

  ld_extend u_ld_extend (
    .raw    (wb_ld_data),
    .off    (wb_alu_out[1:0]),
    .funct3 (wb_funct3),
    .ext    (ld_val)
  );

  always_comb begin
    case (wb_sel)
      WB_SEL_LD:  wb_data = ld_val;
      WB_SEL_PC4: wb_data = wb_pc_plus4;
      default:    wb_data = wb_alu_out;
    endcase
  end

  assign wb_we_out = wb_valid & wb_reg_w_en & (wb_rd != '0);
  // Bypass is suppressed in reset so reads return 0 while rst is high.
  assign bypass_en = wb_we_out & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we_out) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    if (rs1_addr == '0)                      rs1_data = '0;
    else if (bypass_en && rs1_addr == wb_rd) rs1_data = wb_data;
    else                                     rs1_data = regs[rs1_addr];

    if (rs2_addr == '0)                      rs2_data = '0;
    else if (bypass_en && rs2_addr == wb_rd) rs2_data = wb_data;
    else                                     rs2_data = regs[rs2_addr];
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retire_cnt <= '0;
    else if (wb_valid) retire_cnt <= retire_cnt + 64'd1;
  end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: randomized writeback traffic against an
// array-based reference model, plus directed load-extension, x0, bubble,
// bypass and reset cases.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_reg_w_en;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_funct3;
  logic [31:0] wb_alu_out, wb_ld_data, wb_pc_plus4;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_we_out;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_reg_w_en (wb_reg_w_en),
    .wb_rd       (wb_rd),
    .wb_sel      (wb_sel),
    .wb_funct3   (wb_funct3),
    .wb_alu_out  (wb_alu_out),
    .wb_ld_data  (wb_ld_data),
    .wb_pc_plus4 (wb_pc_plus4),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_data     (wb_data),
    .wb_we_out   (wb_we_out)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];
  longint unsigned mdl_retire;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] raw, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] b, h;
    b = (raw >> (int'(off) * 8)) & 32'hFF;
    h = (raw >> (int'(off[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb();
    if (wb_sel == 2'd1) return ref_ext(wb_ld_data, wb_alu_out[1:0], wb_funct3);
    if (wb_sel == 2'd2) return wb_pc_plus4;
    return wb_alu_out;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [31:0] wv,
                                           input logic we);
    if (rst || a == 5'd0) return 32'd0;
    if (we && a == wb_rd) return wv;
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_retire = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic v, input logic we, input logic [4:0] rd,
                            input logic [1:0] sel, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] ld,
                            input logic [31:0] pc4, input logic [4:0] a1,
                            input logic [4:0] a2);
    wb_valid = v; wb_reg_w_en = we; wb_rd = rd; wb_sel = sel; wb_funct3 = f3;
    wb_alu_out = alu; wb_ld_data = ld; wb_pc_plus4 = pc4;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  // Applies one WB instruction, checks combinational outputs, then clocks it in.
  task automatic step(input logic v, input logic we, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] ld,
                      input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] wv;
    logic        ewe;
    set_inputs(v, we, rd, sel, f3, alu, ld, pc4, a1, a2);
    #1;
    wv  = ref_wb();
    ewe = v && we && (rd != 5'd0);
    exp_q.push_back(wv);
    check("wb_data", {32'd0, wb_data}, {32'd0, exp_q.pop_front()});
    check("wb_we_out", {63'd0, wb_we_out}, {63'd0, ewe});
    check("rs1_data", {32'd0, rs1_data}, {32'd0, ref_read(a1, wv, ewe)});
    check("rs2_data", {32'd0, rs2_data}, {32'd0, ref_read(a2, wv, ewe)});
    @(posedge clk);
    if (!rst) begin
      if (ewe) mdl[rd] = wv;
      if (v) mdl_retire = mdl_retire + 1;
    end
    #1;
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  ld_f3  [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0]  ld_off [8] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};
  logic [31:0] ld_exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};

  initial begin
    logic [4:0] rd, a1, a2;
    set_inputs(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd31);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rs1", {32'd0, rs1_data}, 64'd0);
    check("reset_rs2", {32'd0, rs2_data}, 64'd0);
    rst = 1'b0;

    // writeback sources
    step(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'hFFFF_0000, 32'd0, 32'h0000_0104, 5'd3, 5'd0);
    check("x3_alu", {32'd0, mdl[3]}, 64'hDEAD_BEEF);
    idle_read(5'd3, 5'd1);
    check("x1_pc4", {32'd0, rs2_data}, 64'h0000_0104);

    // load extension table
    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b1, 1'b1, 5'd10, 2'd1, ld_f3[i], {30'd0, ld_off[i]}, 32'h80FF_7F01,
                 32'd0, 5'd10, 5'd0);
      #1;
      check($sformatf("ld_ext_%0d", i), {32'd0, wb_data}, {32'd0, ld_exp[i]});
      step(1'b1, 1'b1, 5'd10, 2'd1, ld_f3[i], {30'd0, ld_off[i]}, 32'h80FF_7F01,
           32'd0, 5'd10, 5'd0);
    end

    // x0 never written
    step(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);
    check("x0_zero", {32'd0, rs1_data}, 64'd0);

    // bubble does not write
    step(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0AAA, 32'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0055, 32'd0, 32'd0, 5'd7, 5'd0);
    idle_read(5'd7, 5'd7);
    check("bubble_x7", {32'd0, rs1_data}, 64'h0000_0AAA);

    // same-cycle bypass on both ports
    step(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h11, 32'd0, 32'd0, 5'd0, 5'd0);
    set_inputs(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h22, 32'd0, 32'd0, 5'd9, 5'd9);
    #1;
    check("bypass_rs1", {32'd0, rs1_data}, 64'h22);
    check("bypass_rs2", {32'd0, rs2_data}, 64'h22);
    step(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h22, 32'd0, 32'd0, 5'd9, 5'd9);
    idle_read(5'd9, 5'd9);
    check("stored_x9", {32'd0, rs1_data}, 64'h22);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), rd,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
           $urandom, a1, a2);
    end

`ifdef WB_RETIRE_CNT_EN
    begin
      logic [9:0] pat;
      longint unsigned base;
      pat  = 10'b1101101101;
      base = mdl_retire;
      for (int i = 9; i >= 0; i--)
        step(pat[i], 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      check("retire_pattern", retire_cnt - base, 64'd7);
      check("retire_model", retire_cnt, mdl_retire);
    end
`endif

    // reset mid-run: stored value and pending write are both discarded
    step(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 5'd0, 5'd0);
    idle_read(5'd5, 5'd0);
    check("x5_before_rst", {32'd0, rs1_data}, 64'h1234_5678);
    set_inputs(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 5'd5, 5'd5);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_rs1_imm", {32'd0, rs1_data}, 64'd0);
    check("rst_rs2_imm", {32'd0, rs2_data}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_retire", retire_cnt, 64'd0);
`endif
    @(posedge clk);
    #1;
    check("rst_hold_rs1", {32'd0, rs1_data}, 64'd0);
    rst = 1'b0;
    idle_read(5'd5, 5'd3);
    check("x5_after_rst", {32'd0, rs1_data}, 64'd0);
    check("x3_after_rst", {32'd0, rs2_data}, 64'd0);
    for (int n = 0; n < 40; n++)
      step(1'b1, 1'b1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
